// File: rtl/bar_stream_fifo.sv
// -----------------------------------------------------------------------------
// bar_stream_fifo
//
// Valid/ready stream buffer placed directly upstream of a bar.in consumer.
// A DEPTH-entry circular buffer decouples a bursty producer from the consumer;
// occupancy is exported for debug and back-pressure monitoring.
//
// Parameters
//   N      payload width in bits (>= 1)
//   DEPTH  number of storage entries (>= 2, any value, not only powers of two)
//   CW     occupancy counter width, derived as $clog2(DEPTH+1)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous, active-high reset (pointers and count only)
//   in_data    in   [N]  upstream payload
//   in_valid   in        upstream payload valid
//   in_ready   out       buffer can accept (not full), from registered state only
//   out_data   out  [N]  payload to consumer (bar.data)
//   out_valid  out       payload valid to consumer (bar.valid)
//   out_ready  in        consumer accept (bar.ready)
//   count      out  [CW] current occupancy, 0..DEPTH
//
// Build option
//   BAR_STREAM_FIFO_FALLTHROUGH_EN  when defined, an empty buffer presents
//   in_data/in_valid straight to the consumer; a word accepted downstream in
//   that same cycle bypasses storage. When undefined (default) the buffer is
//   fully registered: one cycle minimum latency, no in_valid->out_valid path.
// -----------------------------------------------------------------------------
module bar_stream_fifo #(
  parameter int N     = 32,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic wr_en;
  logic rd_en;

  // Pointer increment with wrap at DEPTH-1, so non power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // EMPTY / PARTIAL / FULL are decoded directly from the occupancy counter.
  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_FULL);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign count    = cnt;

`ifdef BAR_STREAM_FIFO_FALLTHROUGH_EN
  // Empty buffer forwards the producer combinationally. A word taken by the
  // consumer in the same cycle never touches storage; otherwise it is stored.
  assign out_valid = empty ? in_valid : 1'b1;
  assign out_data  = empty ? in_data : mem[rp];
  assign wr_en     = push && !(empty && out_ready);
  assign rd_en     = pop && !empty;
`else
  assign out_valid = !empty;
  assign out_data  = mem[rp];
  assign wr_en     = push;
  assign rd_en     = pop;
`endif

  // Control state: pointers and occupancy. Reset wins over push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) wp <= ptr_inc(wp);
      if (rd_en) rp <= ptr_inc(rp);
      cnt <= cnt + CW'(wr_en) - CW'(rd_en);
    end
  end

  // Payload storage is not reset; unwritten entries are never presented
  // because out_valid is derived from the counter. The write is blocked
  // during reset so a flushed buffer does not pick up a stray word.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wp] <= in_data;
  end

endmodule
